spi_cmd_ctrl: RTL and testbench
===============================

# spi_cmd_ctrl

Command controller directly downstream of `spi_data_path`. It consumes the decoded address, command nibble and write words that the SPI data path produces. It turns them into single or auto-incrementing burst transactions on the accelerator's internal register bus, and returns read data on `rdata` ahead of the SPI shift-out. All logic runs on the system clock; SPI-domain crossing is already handled upstream.

## Interface
- `ADDR_W`, 20, register-bus address width (matches `addr`).
- `DATA_W`, 16, data word width (matches `wdata`/`rdata`).
- `ACK_TIMEOUT`, 16, cycles to wait for `reg_ack` before flagging error (≥2).
- `clk` in 1 — system clock, single clock domain.
- `reset` in 1 — synchronous, active-high reset.
- `address_ready` in 1 — 1-cycle pulse: `addr`/`status` valid.
- `addr` in ADDR_W — start address from data path.
- `status` in 4 — command nibble: 4'h1 single read, 4'h2 single write, 4'h3 burst read, 4'h4 burst write; others illegal.
- `data_ready` in 1 — 1-cycle pulse. Write: `wdata` valid. Read: current `rdata` word fully shifted out.
- `wdata` in DATA_W — write word from data path.
- `cs_n_o` in 1 — frame chip-select from data path; rising edge (1 after 0) ends the frame.
- `rdata` out DATA_W — read word to data path; stable until next `data_ready`.
- `reg_addr` out ADDR_W, `reg_wdata` out DATA_W, `reg_we` out 1, `reg_re` out 1 — register-bus request. `reg_we`/`reg_re` are held until `reg_ack`.
- `reg_rdata` in DATA_W, `reg_ack` in 1 — bus response; `reg_rdata` is valid with `reg_ack`.
- `busy` out 1 — high in any state other than IDLE.
- `err` out 1 — sticky error; cleared at next `address_ready`.

## Operation
- Reset values: `rdata`=0, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `busy`=0, `err`=0, state IDLE, timeout counter 0.
- States: IDLE, RD_REQ, RD_HOLD, WR_WAIT, WR_REQ, DRAIN.
- IDLE + `address_ready`:
  - Latch `addr` into `reg_addr` and `status` into the command register; clear `err`.
  - Read commands go to RD_REQ. Write commands go to WR_WAIT.
  - Illegal command: set `err`, go to DRAIN.
- RD_REQ: assert `reg_re`. On `reg_ack`, load `reg_rdata` into `rdata`, deassert `reg_re`, go to RD_HOLD.
- RD_HOLD on `data_ready`:
  - Burst read: `reg_addr`+1, go to RD_REQ (prefetch).
  - Single read: go to DRAIN.
- WR_WAIT on `data_ready`: load `wdata` into `reg_wdata`, go to WR_REQ.
- WR_REQ: assert `reg_we`. On `reg_ack`, deassert it.
  - Burst write: `reg_addr`+1, go to WR_WAIT.
  - Single write: go to DRAIN.
- DRAIN: ignore `data_ready`, wait for end of frame.
- Frame end (`cs_n_o` rising) in any state → IDLE next cycle.
  - Any held `reg_we`/`reg_re` drops the same cycle; an aborted request is not retried.
  - `rdata` and `err` keep their values.
- Timeout: the counter runs while `reg_we` or `reg_re` is high. At `ACK_TIMEOUT` cycles without `reg_ack`: drop the request, set `err`, go to DRAIN.
- Address increment is modulo 2^ADDR_W: 20'hFFFFF+1 = 20'h00000, with no error.
- `address_ready` outside IDLE is ignored, and `err` is set.
- `data_ready` in RD_REQ or WR_REQ (data path outran the bus): set `err`, go to DRAIN.

## Timing
- `address_ready` at cycle N → `reg_re`/`reg_we` path starts at N+1 (read: `reg_re` high at N+1).
- `reg_ack` at cycle M → `rdata` updated and `reg_re` low at M+1.
- Write: `data_ready` at N → `reg_we` high at N+1 with `reg_wdata` valid.
- Burst read prefetch: the next `reg_re` is at N+1 after `data_ready` at N. The bus must ack before the next 16-bit shift completes, or `err` is set.
- Precedence within one cycle: frame end > timeout > `reg_ack` > `data_ready`.
- Reset mid-transaction: all outputs return to reset values on the next edge; the bus request drops immediately.

## Structure
- Shared package `spi_pkg`:
  - Command encodings CMD_RD=4'h1, CMD_WR=4'h2, CMD_BRD=4'h3, CMD_BWR=4'h4.
  - State enum.
  - ADDR_W/DATA_W defaults.
- One sub-module, `ack_timer`: load, count-enable and expired flag, parameterised by `ACK_TIMEOUT`.
- Everything else lives in a single FSM module; expected size about 200 RTL lines.

## Test plan
- Single read: status 4'h1, addr 20'h00010; bus acks after 3 cycles with 16'hC69A → `reg_re` held 3 cycles, `rdata`=16'hC69A, `err`=0.
- Single write: status 4'h2, addr 20'h00020, `wdata` 16'h8BFA → one `reg_we` with `reg_addr`=20'h00020, `reg_wdata`=16'h8BFA; later `data_ready` pulses are ignored.
- Burst read of 3 words from 20'hFFFFE → `reg_addr` sequence FFFFE, FFFFF, 00000; `rdata` follows bus data.
- Burst write of 4 words; `cs_n_o` rises after the 2nd word → exactly 2 writes, FSM in IDLE, `busy`=0.
- No `reg_ack` for `ACK_TIMEOUT` cycles → request drops, `err`=1 until the next `address_ready`.
- Illegal status 4'hF → no bus activity, `err`=1; `reset` asserted mid-burst → all outputs zero on the next cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command controller:
// command encodings, FSM states and default widths.
package spi_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    localparam logic [3:0] CMD_RD  = 4'h1;
    localparam logic [3:0] CMD_WR  = 4'h2;
    localparam logic [3:0] CMD_BRD = 4'h3;
    localparam logic [3:0] CMD_BWR = 4'h4;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_HOLD,
        WR_WAIT,
        WR_REQ,
        DRAIN
    } state_t;

endpackage

// File: rtl/ack_timer.sv
// Counts cycles of an outstanding bus request; expired is
// raised on the ACK_TIMEOUT-th cycle the request is held.
module ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign expired = en && (cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Turns decoded SPI commands into single or auto-incrementing
// burst transactions on the internal register bus.
module spi_cmd_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              address_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        status,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cs_n_o,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack,
    output logic              busy,
    output logic              err
);

    state_t     state;
    logic [3:0] cmd;
    logic       cs_q;
    logic       cs_rise;
    logic       req;
    logic       idle_req;
    logic       expired;
    logic       burst;

    assign req      = reg_we | reg_re;
    assign idle_req = ~req;
    assign cs_rise  = cs_n_o & ~cs_q;
    assign busy     = (state != IDLE);
    assign burst    = (cmd == CMD_BRD) || (cmd == CMD_BWR);

    ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (idle_req),
        .en     (req),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd       <= '0;
            cs_q      <= 1'b1;
            rdata     <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            err       <= 1'b0;
        end else begin
            cs_q <= cs_n_o;
            if (cs_rise) begin
                state  <= IDLE;
                reg_we <= 1'b0;
                reg_re <= 1'b0;
            end else if (expired) begin
                state  <= DRAIN;
                reg_we <= 1'b0;
                reg_re <= 1'b0;
                err    <= 1'b1;
            end else begin
                if (address_ready && state != IDLE) begin
                    err <= 1'b1;
                end
                unique case (state)
                    IDLE: begin
                        if (address_ready) begin
                            reg_addr <= addr;
                            cmd      <= status;
                            err      <= 1'b0;
                            case (status)
                                CMD_RD, CMD_BRD: begin
                                    reg_re <= 1'b1;
                                    state  <= RD_REQ;
                                end
                                CMD_WR, CMD_BWR: begin
                                    state <= WR_WAIT;
                                end
                                default: begin
                                    err   <= 1'b1;
                                    state <= DRAIN;
                                end
                            endcase
                        end
                    end
                    RD_REQ: begin
                        if (reg_ack) begin
                            rdata  <= reg_rdata;
                            reg_re <= 1'b0;
                            state  <= RD_HOLD;
                        end else if (data_ready) begin
                            reg_re <= 1'b0;
                            err    <= 1'b1;
                            state  <= DRAIN;
                        end
                    end
                    RD_HOLD: begin
                        if (data_ready) begin
                            if (burst) begin
                                // prefetch the next word while it shifts out
                                reg_addr <= reg_addr + ADDR_W'(1);
                                reg_re   <= 1'b1;
                                state    <= RD_REQ;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                    WR_WAIT: begin
                        if (data_ready) begin
                            reg_wdata <= wdata;
                            reg_we    <= 1'b1;
                            state     <= WR_REQ;
                        end
                    end
                    WR_REQ: begin
                        if (reg_ack) begin
                            reg_we <= 1'b0;
                            if (burst) begin
                                reg_addr <= reg_addr + ADDR_W'(1);
                                state    <= WR_WAIT;
                            end else begin
                                state <= DRAIN;
                            end
                        end else if (data_ready) begin
                            reg_we <= 1'b0;
                            err    <= 1'b1;
                            state  <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        state <= DRAIN;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed frames from the test plan
// followed by randomized frames against a transaction-level model.
module tb_spi_cmd_ctrl;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          address_ready;
    logic [AW-1:0] addr;
    logic [3:0]    status;
    logic          data_ready;
    logic [DW-1:0] wdata;
    logic          cs_n_o;
    logic [DW-1:0] rdata;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [DW-1:0] reg_rdata;
    logic          reg_ack;
    logic          busy;
    logic          err;
    logic          req;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;

    assign req = reg_re | reg_we;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address_ready(address_ready),
        .addr         (addr),
        .status       (status),
        .data_ready   (data_ready),
        .wdata        (wdata),
        .cs_n_o       (cs_n_o),
        .rdata        (rdata),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .reg_ack      (reg_ack),
        .busy         (busy),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        address_ready = 1'b0;
        data_ready    = 1'b0;
        reg_ack       = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, reg_we, 0);
        check({tag, "_re"}, reg_re, 0);
        check({tag, "_addr"}, reg_addr, 0);
        check({tag, "_wdata"}, reg_wdata, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // mode: 0 normal, 1 no ack (timeout), 2 data path overrun,
    // 3 stray address_ready mid-frame
    task automatic run_frame(input logic [3:0] cmd, input logic [AW-1:0] a,
                             input int n, input int lat, input int mode,
                             input logic [DW-1:0] seed);
        bit            legal;
        bit            is_rd;
        bit            burst;
        bit            aborted;
        int            words;
        int            hi;
        logic [AW-1:0] ea;
        logic [DW-1:0] d;
        legal   = (cmd >= 4'h1) && (cmd <= 4'h4);
        is_rd   = (cmd == 4'h1) || (cmd == 4'h3);
        burst   = (cmd == 4'h3) || (cmd == 4'h4);
        words   = burst ? n : 1;
        aborted = 0;
        cs_n_o  = 1'b0;
        step();
        addr          = a;
        status        = cmd;
        address_ready = 1'b1;
        step();
        check("busy_start", busy, 1);
        check("err_start", err, {31'd0, !legal});
        exp_err = !legal;
        for (int i = 0; i < n; i++) begin
            ea = AW'((int'(a) + i) % (1 << AW));
            d  = seed + DW'(i * 4369);
            if (!legal || aborted || i >= words) begin
                wdata      = d;
                data_ready = 1'b1;
                step();
                check("ignored_req", req, 0);
                check("drain_busy", busy, 1);
                continue;
            end
            if (!is_rd) begin
                repeat ($urandom_range(0, 2)) step();
                wdata      = d;
                data_ready = 1'b1;
                step();
                check("wr_we", reg_we, 1);
                check("wr_addr", reg_addr, ea);
                check("wr_data", reg_wdata, d);
            end else begin
                check("rd_re", reg_re, 1);
                check("rd_addr", reg_addr, ea);
            end
            if (mode == 1 && i == 0) begin
                hi = 1;
                while (hi < 40) begin
                    step();
                    if (!req) break;
                    hi++;
                end
                check("to_len", hi, TO);
                check("to_err", err, 1);
                check("to_busy", busy, 1);
                aborted = 1;
                exp_err = 1'b1;
                continue;
            end
            if (mode == 2 && i == 0) begin
                data_ready = 1'b1;
                step();
                check("ovr_req", req, 0);
                check("ovr_err", err, 1);
                aborted = 1;
                exp_err = 1'b1;
                continue;
            end
            repeat (lat - 1) begin
                step();
                check("hold", req, 1);
            end
            reg_ack   = 1'b1;
            reg_rdata = is_rd ? d : ~d;
            step();
            check("ack_drop", req, 0);
            if (is_rd) exp_rdata = d;
            check("rdata", rdata, exp_rdata);
            if (is_rd) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    check("rd_stable", rdata, exp_rdata);
                end
                data_ready = 1'b1;
                step();
                check("prefetch", reg_re, {31'd0, burst});
            end
            if (mode == 3 && i == 0) begin
                addr          = ~a;
                address_ready = 1'b1;
                step();
                check("stray_err", err, 1);
                exp_err = 1'b1;
            end
        end
        repeat ($urandom_range(0, 2)) step();
        cs_n_o = 1'b1;
        step();
        check("end_busy", busy, 0);
        check("end_req", req, 0);
        check("end_err", err, {31'd0, exp_err});
        check("end_rdata", rdata, exp_rdata);
        repeat (2) step();
        check("idle_req", req, 0);
    endtask

    initial begin
        logic [3:0]    cmd;
        logic [AW-1:0] a;
        int            mode;
        reset         = 1'b1;
        address_ready = 1'b0;
        addr          = '0;
        status        = '0;
        data_ready    = 1'b0;
        wdata         = '0;
        cs_n_o        = 1'b1;
        reg_rdata     = '0;
        reg_ack       = 1'b0;
        exp_rdata     = '0;
        exp_err       = 1'b0;
        repeat (3) step();
        check_zero("reset");
        reset = 1'b0;
        step();

        run_frame(4'h1, 20'h00010, 1, 3, 0, 16'hC69A);
        run_frame(4'h2, 20'h00020, 3, 2, 0, 16'h8BFA);
        run_frame(4'h3, 20'hFFFFE, 3, 2, 0, 16'h0123);
        run_frame(4'h4, 20'h00100, 2, 1, 0, 16'h4567);
        run_frame(4'h1, 20'h00040, 1, 1, 1, 16'h89AB);
        run_frame(4'h2, 20'h00050, 1, 2, 0, 16'hCDEF);
        run_frame(4'hF, 20'h00060, 2, 1, 0, 16'h1111);
        run_frame(4'h4, 20'hFFFFF, 3, 1, 2, 16'h2222);
        run_frame(4'h3, 20'h00070, 2, 2, 3, 16'h3333);

        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) < 9)
                cmd = 4'($urandom_range(1, 4));
            else
                cmd = 4'($urandom_range(5, 15));
            if ($urandom_range(0, 3) == 0)
                a = 20'hFFFFF - AW'($urandom_range(0, 2));
            else
                a = AW'($urandom);
            mode = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            run_frame(cmd, a, $urandom_range(1, 4), $urandom_range(1, 4),
                      mode, DW'($urandom));
        end

        cs_n_o = 1'b0;
        step();
        addr          = 20'h12345;
        status        = 4'h4;
        address_ready = 1'b1;
        step();
        wdata      = 16'h5A5A;
        data_ready = 1'b1;
        step();
        check("pre_rst_we", reg_we, 1);
        reset = 1'b1;
        step();
        check_zero("midrst");
        reset     = 1'b0;
        cs_n_o    = 1'b1;
        exp_rdata = '0;
        step();
        run_frame(4'h1, 20'h00080, 1, 2, 0, 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
